// File: rtl/isdu_param.sv
// LC-3 instruction sequencer / decoder.
// Drives the datapath loads, gates and mux selects and the SRAM strobes for fetch, decode and execute.
// Every SRAM access is timed by a shared counter that is cleared whenever a memory state is entered.
// The counter either counts MEM_WAIT cycles or, with USE_READY, waits for Mem_Ready up to a timeout.
//
//  state       | meaning
//  ------------+------------------------------------------------------------
//  S_HALTED    | idle, all outputs low, waits for Run
//  S_FETCH_MAR | MAR <- PC, PC <- PC+1
//  S_FETCH_RD  | instruction read, Mem_OE held for the access
//  S_FETCH_IR  | IR <- MDR
//  S_DECODE    | BEN latched, dispatch on opcode
//  S_ADD       | DR <- SR1 + SR2/imm5
//  S_AND       | DR <- SR1 & SR2/imm5
//  S_NOT       | DR <- ~SR1
//  S_BR        | branch test on BEN
//  S_BR_TAKEN  | PC <- PC + offset9
//  S_JMP       | PC <- BaseR
//  S_JSR_R7    | R7 <- PC
//  S_JSR_PC    | PC <- PC + offset11
//  S_EA        | MAR <- effective address (BaseR+offset6 or PC+offset9)
//  S_MEM_RD    | data read, Mem_OE held for the access
//  S_LD_WB     | DR <- MDR, condition codes updated
//  S_ST_MDR    | MDR <- SR (ALU pass-through)
//  S_MEM_WR    | data write, Mem_WE held for the access
//  S_LEA       | DR <- PC + offset9
//  S_PAUSE1    | LED shows IR, waits for Continue to rise
//  S_PAUSE2    | LED shows IR, waits for Continue to fall
module isdu_param #(
  parameter int MEM_WAIT  = 3,
  parameter int USE_READY = 0,
  parameter int TIMEOUT   = 64,
  parameter int PAUSE_EN  = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  input  logic       Mem_Ready,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_OE,
  output logic       Mem_WE,
  output logic       Fault
);

  typedef enum logic [4:0] {
    S_HALTED, S_FETCH_MAR, S_FETCH_RD, S_FETCH_IR, S_DECODE,
    S_ADD, S_AND, S_NOT, S_BR, S_BR_TAKEN, S_JMP, S_JSR_R7, S_JSR_PC,
    S_EA, S_MEM_RD, S_LD_WB, S_ST_MDR, S_MEM_WR, S_LEA, S_PAUSE1, S_PAUSE2
  } state_t;

  // Counter must hold both the fixed wait length and the ready timeout.
  localparam int CNT_MAX = (TIMEOUT > MEM_WAIT) ? TIMEOUT : MEM_WAIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;

  logic acc_done;
  logic acc_tmo;
  logic rd_load;
  logic unused_ir11;

  // JSR always takes the PC-relative form, so IR_11 has no effect on sequencing.
  assign unused_ir11 = IR_11;

  // Access completion, timeout and MDR-load qualifiers shared by all three memory states.
  always_comb begin
    if (USE_READY != 0) begin
      acc_done = Mem_Ready;
      acc_tmo  = !Mem_Ready && (cnt_q == TMO_LAST);
      rd_load  = Mem_Ready;
    end else begin
      acc_done = (cnt_q == WAIT_LAST);
      acc_tmo  = 1'b0;
      rd_load  = (cnt_q != '0) || (MEM_WAIT == 1);
    end
  end

  // State, access counter and sticky fault registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_HALTED;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign Fault = fault_q;

  // Next-state and control outputs; everything defaults low and the counter clears outside memory waits.
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    fault_d    = fault_q;
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    LD_LED     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = 2'b00;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    SR2MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = 2'b00;
    ALUK       = 2'b00;
    Mem_OE     = 1'b0;
    Mem_WE     = 1'b0;

    case (state_q)
      S_HALTED: begin
        if (Run) state_d = S_FETCH_MAR;
      end
      S_FETCH_MAR: begin
        GatePC  = 1'b1;
        LD_MAR  = 1'b1;
        LD_PC   = 1'b1;
        PCMUX   = 2'b00;
        state_d = S_FETCH_RD;
      end
      S_FETCH_RD: begin
        Mem_OE = 1'b1;
        LD_MDR = rd_load;
        if (acc_tmo) begin
          fault_d = 1'b1;
          state_d = S_HALTED;
        end else if (acc_done) begin
          state_d = S_FETCH_IR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FETCH_IR: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        LD_BEN = 1'b1;
        case (Opcode)
          4'b0001: state_d = S_ADD;
          4'b0101: state_d = S_AND;
          4'b1001: state_d = S_NOT;
          4'b0000: state_d = S_BR;
          4'b1100: state_d = S_JMP;
          4'b0100: state_d = S_JSR_R7;
          4'b0110, 4'b0111, 4'b0010, 4'b0011: state_d = S_EA;
          4'b1110: state_d = S_LEA;
          4'b1101: state_d = (PAUSE_EN != 0) ? S_PAUSE1 : S_FETCH_MAR;
          default: state_d = S_FETCH_MAR;
        endcase
      end
      S_ADD, S_AND, S_NOT: begin
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
        SR2MUX  = IR_5;
        ALUK    = (state_q == S_ADD) ? 2'b00 : (state_q == S_AND) ? 2'b01 : 2'b10;
        state_d = S_FETCH_MAR;
      end
      S_BR: begin
        state_d = BEN ? S_BR_TAKEN : S_FETCH_MAR;
      end
      S_BR_TAKEN: begin
        LD_PC    = 1'b1;
        PCMUX    = 2'b01;
        ADDR2MUX = 2'b10;
        state_d  = S_FETCH_MAR;
      end
      S_JMP: begin
        LD_PC    = 1'b1;
        PCMUX    = 2'b01;
        ADDR1MUX = 1'b1;
        state_d  = S_FETCH_MAR;
      end
      S_JSR_R7: begin
        GatePC  = 1'b1;
        LD_REG  = 1'b1;
        DRMUX   = 1'b1;
        state_d = S_JSR_PC;
      end
      S_JSR_PC: begin
        LD_PC    = 1'b1;
        PCMUX    = 2'b01;
        ADDR2MUX = 2'b11;
        state_d  = S_FETCH_MAR;
      end
      S_EA: begin
        // Opcode[2] separates base-relative LDR/STR from PC-relative LD/ST; Opcode[0] marks stores.
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
        ADDR1MUX   = Opcode[2];
        ADDR2MUX   = Opcode[2] ? 2'b01 : 2'b10;
        state_d    = Opcode[0] ? S_ST_MDR : S_MEM_RD;
      end
      S_MEM_RD: begin
        Mem_OE = 1'b1;
        LD_MDR = rd_load;
        if (acc_tmo) begin
          fault_d = 1'b1;
          state_d = S_HALTED;
        end else if (acc_done) begin
          state_d = S_LD_WB;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LD_WB: begin
        GateMDR = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
        state_d = S_FETCH_MAR;
      end
      S_ST_MDR: begin
        GateALU = 1'b1;
        LD_MDR  = 1'b1;
        SR1MUX  = 1'b1;
        ALUK    = 2'b11;
        state_d = S_MEM_WR;
      end
      S_MEM_WR: begin
        Mem_WE = 1'b1;
        if (acc_tmo) begin
          fault_d = 1'b1;
          state_d = S_HALTED;
        end else if (acc_done) begin
          state_d = S_FETCH_MAR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LEA: begin
        GateMARMUX = 1'b1;
        ADDR2MUX   = 2'b10;
        LD_REG     = 1'b1;
        LD_CC      = 1'b1;
        state_d    = S_FETCH_MAR;
      end
      S_PAUSE1: begin
        LD_LED = 1'b1;
        if (Continue) state_d = S_PAUSE2;
      end
      S_PAUSE2: begin
        LD_LED = 1'b1;
        if (!Continue) state_d = S_FETCH_MAR;
      end
      default: begin
        state_d = S_FETCH_MAR;
      end
    endcase
  end

endmodule

// File: tb/tb_isdu_param.sv
// Bench for isdu_param: three configurations (fixed 3-cycle wait, fixed 1-cycle wait without
// pause, Mem_Ready handshake with short timeout), each driven by directed and random instructions
// and compared cycle by cycle against an instruction-level reference of the control words.
module tb_isdu_param;

  typedef struct packed {
    logic       fault;
    logic       mem_oe, mem_we;
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic       drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux, aluk;
  } cw_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_i[3], run_i[3], cont_i[3], ir5_i[3], ir11_i[3], ben_i[3], rdy_i[3];
  logic [3:0] op_i[3];
  cw_t        obs0, obs1, obs2;

  int n_tests = 0;
  int n_fail  = 0;

  int mw[3]       = '{3, 1, 3};
  bit use_rdy[3]  = '{1'b0, 1'b0, 1'b1};
  int tmo_cyc[3]  = '{64, 64, 8};
  bit pause_en[3] = '{1'b1, 1'b0, 1'b1};
  bit flt[3]      = '{1'b0, 1'b0, 1'b0};

  isdu_param #(.MEM_WAIT(3), .USE_READY(0), .TIMEOUT(64), .PAUSE_EN(1)) u_dut0 (
    .Clk(clk), .Reset(rst_i[0]), .Run(run_i[0]), .Continue(cont_i[0]), .Opcode(op_i[0]),
    .IR_5(ir5_i[0]), .IR_11(ir11_i[0]), .BEN(ben_i[0]), .Mem_Ready(rdy_i[0]),
    .LD_MAR(obs0.ld_mar), .LD_MDR(obs0.ld_mdr), .LD_IR(obs0.ld_ir), .LD_BEN(obs0.ld_ben),
    .LD_CC(obs0.ld_cc), .LD_REG(obs0.ld_reg), .LD_PC(obs0.ld_pc), .LD_LED(obs0.ld_led),
    .GatePC(obs0.gate_pc), .GateMDR(obs0.gate_mdr), .GateALU(obs0.gate_alu),
    .GateMARMUX(obs0.gate_marmux), .PCMUX(obs0.pcmux), .DRMUX(obs0.drmux), .SR1MUX(obs0.sr1mux),
    .SR2MUX(obs0.sr2mux), .ADDR1MUX(obs0.addr1mux), .ADDR2MUX(obs0.addr2mux), .ALUK(obs0.aluk),
    .Mem_OE(obs0.mem_oe), .Mem_WE(obs0.mem_we), .Fault(obs0.fault)
  );

  isdu_param #(.MEM_WAIT(1), .USE_READY(0), .TIMEOUT(64), .PAUSE_EN(0)) u_dut1 (
    .Clk(clk), .Reset(rst_i[1]), .Run(run_i[1]), .Continue(cont_i[1]), .Opcode(op_i[1]),
    .IR_5(ir5_i[1]), .IR_11(ir11_i[1]), .BEN(ben_i[1]), .Mem_Ready(rdy_i[1]),
    .LD_MAR(obs1.ld_mar), .LD_MDR(obs1.ld_mdr), .LD_IR(obs1.ld_ir), .LD_BEN(obs1.ld_ben),
    .LD_CC(obs1.ld_cc), .LD_REG(obs1.ld_reg), .LD_PC(obs1.ld_pc), .LD_LED(obs1.ld_led),
    .GatePC(obs1.gate_pc), .GateMDR(obs1.gate_mdr), .GateALU(obs1.gate_alu),
    .GateMARMUX(obs1.gate_marmux), .PCMUX(obs1.pcmux), .DRMUX(obs1.drmux), .SR1MUX(obs1.sr1mux),
    .SR2MUX(obs1.sr2mux), .ADDR1MUX(obs1.addr1mux), .ADDR2MUX(obs1.addr2mux), .ALUK(obs1.aluk),
    .Mem_OE(obs1.mem_oe), .Mem_WE(obs1.mem_we), .Fault(obs1.fault)
  );

  isdu_param #(.MEM_WAIT(3), .USE_READY(1), .TIMEOUT(8), .PAUSE_EN(1)) u_dut2 (
    .Clk(clk), .Reset(rst_i[2]), .Run(run_i[2]), .Continue(cont_i[2]), .Opcode(op_i[2]),
    .IR_5(ir5_i[2]), .IR_11(ir11_i[2]), .BEN(ben_i[2]), .Mem_Ready(rdy_i[2]),
    .LD_MAR(obs2.ld_mar), .LD_MDR(obs2.ld_mdr), .LD_IR(obs2.ld_ir), .LD_BEN(obs2.ld_ben),
    .LD_CC(obs2.ld_cc), .LD_REG(obs2.ld_reg), .LD_PC(obs2.ld_pc), .LD_LED(obs2.ld_led),
    .GatePC(obs2.gate_pc), .GateMDR(obs2.gate_mdr), .GateALU(obs2.gate_alu),
    .GateMARMUX(obs2.gate_marmux), .PCMUX(obs2.pcmux), .DRMUX(obs2.drmux), .SR1MUX(obs2.sr1mux),
    .SR2MUX(obs2.sr2mux), .ADDR1MUX(obs2.addr1mux), .ADDR2MUX(obs2.addr2mux), .ALUK(obs2.aluk),
    .Mem_OE(obs2.mem_oe), .Mem_WE(obs2.mem_we), .Fault(obs2.fault)
  );

  function automatic cw_t get_obs(input int k);
    case (k)
      0:       return obs0;
      1:       return obs1;
      default: return obs2;
    endcase
  endfunction

  function automatic cw_t base(input int k);
    cw_t e;
    e = '0;
    e.fault = flt[k];
    return e;
  endfunction

  // Compare one cycle at the falling edge, then move to just after the next rising edge.
  task automatic chk(input int k, input cw_t e, input string tag);
    cw_t o;
    @(negedge clk);
    o = get_obs(k);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s dut%0d: got %h expected %h", tag, k, o, e);
    end
    @(posedge clk);
    #1;
  endtask

  // Inputs that the current state must ignore get random values.
  task automatic noise(input int k);
    run_i[k]  = 1'($urandom);
    rdy_i[k]  = 1'($urandom);
    cont_i[k] = 1'($urandom);
    ir11_i[k] = 1'($urandom);
    ben_i[k]  = 1'($urandom);
    ir5_i[k]  = 1'($urandom);
  endtask

  task automatic start(input int k);
    noise(k);
    run_i[k] = 1'b1;
    chk(k, base(k), "halted_run");
  endtask

  task automatic access(input int k, input bit rd, input bit tmo, output bit ab);
    cw_t e;
    int d;
    ab = 1'b0;
    if (!use_rdy[k]) begin
      for (int i = 0; i < mw[k]; i++) begin
        noise(k);
        e = base(k);
        e.mem_oe = rd;
        e.mem_we = !rd;
        e.ld_mdr = rd && (i > 0 || mw[k] == 1);
        chk(k, e, rd ? "rd_fixed" : "wr_fixed");
      end
    end else if (tmo) begin
      for (int i = 0; i < tmo_cyc[k]; i++) begin
        noise(k);
        rdy_i[k] = 1'b0;
        e = base(k);
        e.mem_oe = rd;
        e.mem_we = !rd;
        chk(k, e, "tmo_wait");
      end
      flt[k] = 1'b1;
      noise(k);
      run_i[k] = 1'b0;
      chk(k, base(k), "tmo_halted");
      ab = 1'b1;
    end else begin
      d = int'($urandom_range(3, 0));
      for (int i = 0; i <= d; i++) begin
        noise(k);
        rdy_i[k] = (i == d);
        e = base(k);
        e.mem_oe = rd;
        e.mem_we = !rd;
        e.ld_mdr = rd && (i == d);
        chk(k, e, rd ? "rd_ready" : "wr_ready");
      end
    end
  endtask

  // Expected control words for one whole instruction, starting and ending in FETCH_MAR.
  task automatic run_instr(input int k, input logic [3:0] op, input logic ir5, input logic ben,
                           input bit tmo);
    cw_t e;
    bit  ab;
    bit  base_rel, store;
    int  n;
    op_i[k] = op;
    noise(k);
    e = base(k); e.gate_pc = 1; e.ld_mar = 1; e.ld_pc = 1;
    chk(k, e, "fetch_mar");
    access(k, 1'b1, 1'b0, ab);
    noise(k);
    e = base(k); e.gate_mdr = 1; e.ld_ir = 1;
    chk(k, e, "fetch_ir");
    noise(k);
    e = base(k); e.ld_ben = 1;
    chk(k, e, "decode");
    case (op)
      4'b0001, 4'b0101, 4'b1001: begin
        noise(k);
        ir5_i[k] = ir5;
        e = base(k); e.gate_alu = 1; e.ld_reg = 1; e.ld_cc = 1; e.sr2mux = ir5;
        e.aluk = (op == 4'b0001) ? 2'b00 : (op == 4'b0101) ? 2'b01 : 2'b10;
        chk(k, e, "alu");
      end
      4'b0000: begin
        noise(k);
        ben_i[k] = ben;
        chk(k, base(k), "br");
        if (ben) begin
          noise(k);
          e = base(k); e.ld_pc = 1; e.pcmux = 2'b01; e.addr2mux = 2'b10;
          chk(k, e, "br_taken");
        end
      end
      4'b1100: begin
        noise(k);
        e = base(k); e.ld_pc = 1; e.pcmux = 2'b01; e.addr1mux = 1;
        chk(k, e, "jmp");
      end
      4'b0100: begin
        noise(k);
        e = base(k); e.gate_pc = 1; e.ld_reg = 1; e.drmux = 1;
        chk(k, e, "jsr_r7");
        noise(k);
        e = base(k); e.ld_pc = 1; e.pcmux = 2'b01; e.addr2mux = 2'b11;
        chk(k, e, "jsr_pc");
      end
      4'b0110, 4'b0111, 4'b0010, 4'b0011: begin
        base_rel = (op == 4'b0110) || (op == 4'b0111);
        store    = (op == 4'b0111) || (op == 4'b0011);
        noise(k);
        e = base(k); e.gate_marmux = 1; e.ld_mar = 1; e.addr1mux = base_rel;
        e.addr2mux = base_rel ? 2'b01 : 2'b10;
        chk(k, e, "ea");
        if (!store) begin
          access(k, 1'b1, tmo, ab);
          if (!ab) begin
            noise(k);
            e = base(k); e.gate_mdr = 1; e.ld_reg = 1; e.ld_cc = 1;
            chk(k, e, "ld_wb");
          end
        end else begin
          noise(k);
          e = base(k); e.gate_alu = 1; e.ld_mdr = 1; e.sr1mux = 1; e.aluk = 2'b11;
          chk(k, e, "st_mdr");
          access(k, 1'b0, tmo, ab);
        end
      end
      4'b1110: begin
        noise(k);
        e = base(k); e.gate_marmux = 1; e.addr2mux = 2'b10; e.ld_reg = 1; e.ld_cc = 1;
        chk(k, e, "lea");
      end
      4'b1101: begin
        if (pause_en[k]) begin
          e = base(k); e.ld_led = 1;
          n = int'($urandom_range(2, 0));
          for (int i = 0; i < n; i++) begin
            noise(k); cont_i[k] = 1'b0; chk(k, e, "pause1_wait");
          end
          noise(k); cont_i[k] = 1'b1; chk(k, e, "pause1_rise");
          n = int'($urandom_range(2, 0));
          for (int i = 0; i < n; i++) begin
            noise(k); cont_i[k] = 1'b1; chk(k, e, "pause2_wait");
          end
          noise(k); cont_i[k] = 1'b0; chk(k, e, "pause2_fall");
        end
      end
      default: ;
    endcase
  endtask

  task automatic rand_instr(input int k);
    run_instr(k, 4'($urandom_range(15, 0)), 1'($urandom), 1'($urandom), 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cw_t e;
    for (int k = 0; k < 3; k++) begin
      rst_i[k] = 1'b1; run_i[k] = 1'b0; cont_i[k] = 1'b0; ir5_i[k] = 1'b0;
      ir11_i[k] = 1'b0; ben_i[k] = 1'b0; rdy_i[k] = 1'b0; op_i[k] = 4'b0000;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) rst_i[k] = 1'b0;

    // Reset state, and HALTED ignores everything but Run.
    for (int k = 0; k < 3; k++) begin
      chk(k, base(k), "reset_halted");
      noise(k); run_i[k] = 1'b0;
      chk(k, base(k), "halted_idle");
    end

    // Fixed 3-cycle wait with pause enabled.
    start(0);
    run_instr(0, 4'b0001, 1'b1, 1'b0, 1'b0);
    run_instr(0, 4'b0000, 1'b0, 1'b0, 1'b0);
    run_instr(0, 4'b0000, 1'b0, 1'b1, 1'b0);
    run_instr(0, 4'b1101, 1'b0, 1'b0, 1'b0);
    run_instr(0, 4'b0111, 1'b0, 1'b0, 1'b0);
    run_instr(0, 4'b0110, 1'b0, 1'b0, 1'b0);
    run_instr(0, 4'b0010, 1'b0, 1'b0, 1'b0);
    run_instr(0, 4'b0011, 1'b0, 1'b0, 1'b0);
    run_instr(0, 4'b1110, 1'b0, 1'b0, 1'b0);
    run_instr(0, 4'b1100, 1'b0, 1'b0, 1'b0);
    run_instr(0, 4'b0100, 1'b0, 1'b0, 1'b0);
    run_instr(0, 4'b0101, 1'b0, 1'b0, 1'b0);
    run_instr(0, 4'b1001, 1'b1, 1'b0, 1'b0);
    run_instr(0, 4'b1000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) rand_instr(0);

    // Synchronous reset in the middle of an instruction fetch.
    op_i[0] = 4'b0001;
    noise(0);
    e = base(0); e.gate_pc = 1; e.ld_mar = 1; e.ld_pc = 1;
    chk(0, e, "rst_fetch_mar");
    noise(0);
    e = base(0); e.mem_oe = 1;
    chk(0, e, "rst_rd_c1");
    noise(0); rst_i[0] = 1'b1;
    e = base(0); e.mem_oe = 1; e.ld_mdr = 1;
    chk(0, e, "rst_rd_c2");
    rst_i[0] = 1'b0; run_i[0] = 1'b0;
    chk(0, base(0), "rst_abort");

    // Single-cycle fixed wait, pause opcode behaves as a NOP.
    start(1);
    run_instr(1, 4'b0111, 1'b0, 1'b0, 1'b0);
    run_instr(1, 4'b0110, 1'b0, 1'b0, 1'b0);
    run_instr(1, 4'b1101, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) rand_instr(1);

    // Ready handshake, then a timeout in MEM_RD, restart with the fault still set, then reset.
    start(2);
    for (int i = 0; i < 20; i++) rand_instr(2);
    run_instr(2, 4'b0110, 1'b0, 1'b0, 1'b1);
    noise(2); run_i[2] = 1'b0;
    chk(2, base(2), "fault_halted");
    start(2);
    run_instr(2, 4'b0001, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) rand_instr(2);
    rst_i[2] = 1'b1;
    run_i[2] = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_i[2] = 1'b0;
    flt[2] = 1'b0;
    chk(2, base(2), "fault_cleared");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
